// File: rtl/tcb_lib_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tcb_lib_mem_arb
//  Purpose  : Single-port byte-enabled memory shared by SPN request ports
//             through a round-robin arbiter, with a fixed read response
//             latency of DLY cycles (DLY=0 answers combinationally).
//
//  Ports    :
//    clk          in   clock, all state changes on the rising edge
//    rst_n        in   synchronous active-low reset
//    tcb_vld      in   [SPN]        request valid per port
//    tcb_rdy      out  [SPN]        grant, at most one bit set per cycle
//    tcb_wen      in   [SPN]        1 = write, 0 = read
//    tcb_adr      in   [SPN][AW]    byte address
//    tcb_ben      in   [SPN][DW/8]  byte enables
//    tcb_wdt      in   [SPN][DW]    write data
//    tcb_rsp_vld  out  [SPN]        response valid (one-cycle pulse)
//    tcb_rdt      out  [SPN][DW]    read data, zero when no response
//    tcb_err      out  [SPN]        out-of-range error, zero when no response
//
//  Revision : 1.0  initial release
// ============================================================================
module tcb_lib_mem_arb #(
    parameter int SPN = 2,      // number of request ports (1..8)
    parameter int AW  = 16,     // byte address width
    parameter int DW  = 32,     // data width (8, 16, 32, 64)
    parameter int SIZ = 4096,   // memory size in bytes
    parameter int DLY = 1       // response latency in cycles (0..4)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [SPN-1:0]               tcb_vld,
    output logic [SPN-1:0]               tcb_rdy,
    input  logic [SPN-1:0]               tcb_wen,
    input  logic [SPN-1:0][AW-1:0]       tcb_adr,
    input  logic [SPN-1:0][DW/8-1:0]     tcb_ben,
    input  logic [SPN-1:0][DW-1:0]       tcb_wdt,
    output logic [SPN-1:0]               tcb_rsp_vld,
    output logic [SPN-1:0][DW-1:0]       tcb_rdt,
    output logic [SPN-1:0]               tcb_err
);

    localparam int BEW = DW / 8;                          // bytes per word
    localparam int BL  = (BEW > 1) ? $clog2(BEW) : 0;     // byte-offset bits
    localparam int MW  = SIZ / BEW;                       // words in memory
    localparam int IW  = (MW > 1) ? $clog2(MW) : 1;       // word index width
    localparam int PW  = (SPN > 1) ? $clog2(SPN) : 1;     // pointer width

    // ------------------------------------------------------------------------
    // Round-robin arbitration
    // ------------------------------------------------------------------------
    logic [PW-1:0]  r_ptr;
    logic           w_gnt_any;
    logic [PW-1:0]  w_gnt_idx;
    logic [PW:0]    w_k;

    // Search ptr, ptr+1, ... wrapping at SPN; the first requester wins.
    // Reset suppresses every grant so requests during reset are ignored.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_k       = '0;
        for (int i = 0; i < SPN; i++) begin
            w_k = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_k >= (PW+1)'(SPN)) begin
                w_k = w_k - (PW+1)'(SPN);
            end
            if (rst_n && !w_gnt_any && tcb_vld[w_k[PW-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_k[PW-1:0];
            end
        end
    end

    always_comb begin
        tcb_rdy = '0;
        if (w_gnt_any) begin
            tcb_rdy[w_gnt_idx] = 1'b1;
        end
    end

    // A grant is only ever given to a valid port, so a grant is a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_gnt_any) begin
            r_ptr <= (w_gnt_idx == PW'(SPN-1)) ? '0 : w_gnt_idx + PW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Memory access for the granted port
    // ------------------------------------------------------------------------
    logic [AW-1:0]   w_adr;
    logic            w_wen;
    logic [BEW-1:0]  w_ben;
    logic [DW-1:0]   w_wdt;
    logic            w_oor;
    logic [IW-1:0]   w_idx;
    logic [DW-1:0]   w_word;
    logic [DW-1:0]   w_rdt;

    logic [DW-1:0]   r_mem [MW];

    assign w_adr = tcb_adr[w_gnt_idx];
    assign w_wen = tcb_wen[w_gnt_idx];
    assign w_ben = tcb_ben[w_gnt_idx];
    assign w_wdt = tcb_wdt[w_gnt_idx];

    // Extra MSB keeps the compare valid when SIZ equals 2**AW.
    assign w_oor = ({1'b0, w_adr} >= (AW+1)'(SIZ));

    // Low byte-offset bits are ignored; bits above the index only matter
    // through the out-of-range compare.
    assign w_idx = w_adr[BL+IW-1:BL];

    // Read data is taken combinationally in the transfer cycle, so a read
    // right after a write to the same word sees the new contents.
    always_comb begin
        w_rdt  = '0;
        w_word = r_mem[w_idx];
        if (w_gnt_any && !w_wen && !w_oor) begin
            for (int b = 0; b < BEW; b++) begin
                if (w_ben[b]) begin
                    w_rdt[8*b +: 8] = w_word[8*b +: 8];
                end
            end
        end
    end

    // Memory contents are deliberately left untouched by reset.
    always_ff @(posedge clk) begin
        if (w_gnt_any && w_wen && !w_oor) begin
            for (int b = 0; b < BEW; b++) begin
                if (w_ben[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdt[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-port response in the transfer cycle (zero on non-granted ports)
    // ------------------------------------------------------------------------
    logic [SPN-1:0]          w_pv;
    logic [SPN-1:0]          w_pe;
    logic [SPN-1:0][DW-1:0]  w_pd;

    always_comb begin
        w_pv = tcb_rdy;
        w_pe = tcb_rdy & {SPN{w_oor}};
        w_pd = '0;
        for (int p = 0; p < SPN; p++) begin
            if (tcb_rdy[p]) begin
                w_pd[p] = w_rdt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response delay
    // ------------------------------------------------------------------------
    generate
        if (DLY == 0) begin : g_dly0
            assign tcb_rsp_vld = w_pv;
            assign tcb_err     = w_pe;
            assign tcb_rdt     = w_pd;
        end else begin : g_dly_pipe
            // Stage 0 captures the transfer cycle; stage DLY-1 drives the
            // outputs. Idle stages carry zeros, so outputs are zero whenever
            // the valid bit is low.
            logic [DLY-1:0][SPN-1:0]          r_pv;
            logic [DLY-1:0][SPN-1:0]          r_pe;
            logic [DLY-1:0][SPN-1:0][DW-1:0]  r_pd;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pv <= '0;
                    r_pe <= '0;
                    r_pd <= '0;
                end else begin
                    r_pv[0] <= w_pv;
                    r_pe[0] <= w_pe;
                    r_pd[0] <= w_pd;
                    for (int s = 1; s < DLY; s++) begin
                        r_pv[s] <= r_pv[s-1];
                        r_pe[s] <= r_pe[s-1];
                        r_pd[s] <= r_pd[s-1];
                    end
                end
            end

            assign tcb_rsp_vld = r_pv[DLY-1];
            assign tcb_err     = r_pe[DLY-1];
            assign tcb_rdt     = r_pd[DLY-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tcb_lib_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tcb_lib_mem_arb
//  Purpose  : Self-checking bench for tcb_lib_mem_arb. Three instances with
//             DLY = 0, 1 and 3 share one stimulus stream; a byte-array
//             reference model predicts grants and responses, and each
//             instance's responses are compared against the history of
//             predicted transfers shifted by its latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tcb_lib_mem_arb;

    localparam int SPN = 2;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int BEW = DW / 8;
    localparam int SIZ = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst_n;
    logic [SPN-1:0]            vld;
    logic [SPN-1:0]            wen;
    logic [SPN-1:0][AW-1:0]    adr;
    logic [SPN-1:0][BEW-1:0]   ben;
    logic [SPN-1:0][DW-1:0]    wdt;

    logic [SPN-1:0]            rdy_d0, rdy_d1, rdy_d3;
    logic [SPN-1:0]            rv_d0, rv_d1, rv_d3;
    logic [SPN-1:0][DW-1:0]    rdt_d0, rdt_d1, rdt_d3;
    logic [SPN-1:0]            err_d0, err_d1, err_d3;

    tcb_lib_mem_arb #(.SPN(SPN), .AW(AW), .DW(DW), .SIZ(SIZ), .DLY(0)) u_dut_d0 (
        .clk(clk), .rst_n(rst_n), .tcb_vld(vld), .tcb_rdy(rdy_d0), .tcb_wen(wen),
        .tcb_adr(adr), .tcb_ben(ben), .tcb_wdt(wdt),
        .tcb_rsp_vld(rv_d0), .tcb_rdt(rdt_d0), .tcb_err(err_d0));

    tcb_lib_mem_arb #(.SPN(SPN), .AW(AW), .DW(DW), .SIZ(SIZ), .DLY(1)) u_dut_d1 (
        .clk(clk), .rst_n(rst_n), .tcb_vld(vld), .tcb_rdy(rdy_d1), .tcb_wen(wen),
        .tcb_adr(adr), .tcb_ben(ben), .tcb_wdt(wdt),
        .tcb_rsp_vld(rv_d1), .tcb_rdt(rdt_d1), .tcb_err(err_d1));

    tcb_lib_mem_arb #(.SPN(SPN), .AW(AW), .DW(DW), .SIZ(SIZ), .DLY(3)) u_dut_d3 (
        .clk(clk), .rst_n(rst_n), .tcb_vld(vld), .tcb_rdy(rdy_d3), .tcb_wen(wen),
        .tcb_adr(adr), .tcb_ben(ben), .tcb_wdt(wdt),
        .tcb_rsp_vld(rv_d3), .tcb_rdt(rdt_d3), .tcb_err(err_d3));

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    int           n_vec;
    int           n_bad;
    int           cyc;
    int           m_ptr;
    logic [7:0]   m_mem [SIZ];
    int           h_g   [8];     // granted port per cycle, -1 = none
    bit           h_err [8];
    logic [31:0]  h_rdt [8];
    bit           h_rst [8];     // rst_n level in that cycle

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    task automatic check_rsp(input int d, input logic [SPN-1:0] rv,
                             input logic [SPN-1:0][DW-1:0] rd, input logic [SPN-1:0] er);
        logic [SPN-1:0]          ev;
        logic [SPN-1:0]          ee;
        logic [SPN-1:0][DW-1:0]  ed;
        int s;
        bit ok;
        ev = '0; ee = '0; ed = '0;
        if (d > 0 && !rst_n) return;
        s = cyc - d;
        if (s >= 0 && h_g[s % 8] >= 0) begin
            ok = 1'b1;
            for (int c = s; c < cyc; c++) begin
                if (!h_rst[c % 8]) ok = 1'b0;
            end
            if (ok) begin
                ev[h_g[s % 8]] = 1'b1;
                ee[h_g[s % 8]] = h_err[s % 8];
                ed[h_g[s % 8]] = h_rdt[s % 8];
            end
        end
        check_eq($sformatf("rsp_vld_d%0d", d), 64'(rv), 64'(ev));
        check_eq($sformatf("err_d%0d", d), 64'(er), 64'(ee));
        for (int p = 0; p < SPN; p++) begin
            check_eq($sformatf("rdt_d%0d_p%0d", d, p), 64'(rd[p]), 64'(ed[p]));
        end
    endtask

    // One clock cycle: settle, predict, compare, commit model, advance.
    task automatic tick();
        int g;
        int p;
        int a;
        bit e;
        logic [31:0] r;
        logic [SPN-1:0] xr;
        #1;
        g = -1;
        if (rst_n) begin
            for (int i = 0; i < SPN; i++) begin
                p = (m_ptr + i) % SPN;
                if (g < 0 && vld[p]) g = p;
            end
        end
        xr = '0;
        if (g >= 0) xr[g] = 1'b1;
        check_eq("rdy_d0", 64'(rdy_d0), 64'(xr));
        check_eq("rdy_d1", 64'(rdy_d1), 64'(xr));
        check_eq("rdy_d3", 64'(rdy_d3), 64'(xr));

        e = 1'b0;
        r = '0;
        a = 0;
        if (g >= 0) begin
            a = int'(adr[g]);
            if (a >= SIZ) begin
                e = 1'b1;
            end else if (!wen[g]) begin
                for (int b = 0; b < BEW; b++) begin
                    if (ben[g][b]) r[8*b +: 8] = m_mem[(a / BEW) * BEW + b];
                end
            end
        end
        h_g[cyc % 8]   = g;
        h_err[cyc % 8] = e;
        h_rdt[cyc % 8] = r;
        h_rst[cyc % 8] = rst_n;

        check_rsp(0, rv_d0, rdt_d0, err_d0);
        check_rsp(1, rv_d1, rdt_d1, err_d1);
        check_rsp(3, rv_d3, rdt_d3, err_d3);

        if (g >= 0 && wen[g] && !e) begin
            for (int b = 0; b < BEW; b++) begin
                if (ben[g][b]) m_mem[(a / BEW) * BEW + b] = wdt[g][8*b +: 8];
            end
        end
        if (!rst_n) m_ptr = 0;
        else if (g >= 0) m_ptr = (g + 1) % SPN;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic req(input int p, input bit w, input int a, input logic [3:0] be,
                       input logic [31:0] d);
        vld    = '0;
        vld[p] = 1'b1;
        wen[p] = w;
        adr[p] = AW'(a);
        ben[p] = be;
        wdt[p] = d;
    endtask

    int          cnt0, cnt1;
    logic [31:0] w0_before;

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0; m_ptr = 0;
        for (int i = 0; i < 8; i++) begin
            h_g[i] = -1; h_err[i] = 1'b0; h_rdt[i] = '0; h_rst[i] = 1'b0;
        end
        rst_n = 1'b0; vld = '0; wen = '0; adr = '0; ben = '0; wdt = '0;
        @(posedge clk);
        #1;
        tick();
        // Requests during reset must be ignored.
        vld = '1;
        tick();
        vld = '0;
        rst_n = 1'b1;

        // Fill every word so later reads never hit uninitialised storage.
        for (int w = 0; w < SIZ / BEW; w++) begin
            req(0, 1'b1, w * BEW, 4'hF, $urandom);
            tick();
        end
        vld = '0;
        tick();

        // Write then read the same word back-to-back.
        req(0, 1'b1, 'h10, 4'hF, 32'hA5A5_1234);
        tick();
        req(0, 1'b0, 'h10, 4'hF, 32'h0);
        tick();
        check_eq("s34_vld", 64'(rv_d1[0]), 64'(1));
        check_eq("s34_rdt", 64'(rdt_d1[0]), 64'h0000_0000_A5A5_1234);
        check_eq("s34_err", 64'(err_d1[0]), 64'(0));

        // Partial byte-lane writes and masked reads.
        req(0, 1'b1, 'h20, 4'hF, 32'hFFFF_FFFF);
        tick();
        req(0, 1'b1, 'h20, 4'b0010, 32'h0000_5600);
        tick();
        req(0, 1'b0, 'h22, 4'hF, 32'h0);
        tick();
        check_eq("s35_rd_all", 64'(rdt_d1[0]), 64'h0000_0000_FFFF_56FF);
        req(0, 1'b0, 'h20, 4'b0001, 32'h0);
        #1;
        check_eq("s35_rd_b0_d0", 64'(rdt_d0[0]), 64'h0000_0000_0000_00FF);
        tick();
        check_eq("s35_rd_b0", 64'(rdt_d1[0]), 64'h0000_0000_0000_00FF);

        // Combinational (DLY=0) response.
        req(1, 1'b1, 'h40, 4'hF, 32'h0BAD_F00D);
        tick();
        req(1, 1'b0, 'h40, 4'hF, 32'h0);
        #1;
        check_eq("s39_vld_d0", 64'(rv_d0), 64'b10);
        check_eq("s39_rdt_d0", 64'(rdt_d0[1]), 64'h0000_0000_0BAD_F00D);
        tick();

        // Out-of-range access.
        w0_before = {m_mem[3], m_mem[2], m_mem[1], m_mem[0]};
        req(0, 1'b0, 'h1000, 4'hF, 32'h0);
        tick();
        check_eq("s37_err", 64'(err_d1[0]), 64'(1));
        check_eq("s37_rdt", 64'(rdt_d1[0]), 64'(0));
        req(0, 1'b1, 'h1000, 4'hF, 32'hDEAD_BEEF);
        tick();
        req(0, 1'b0, 'h0, 4'hF, 32'h0);
        tick();
        check_eq("s37_mem_kept", 64'(rdt_d1[0]), 64'(w0_before));

        // Both ports requesting continuously from reset.
        vld = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cnt0 = 0; cnt1 = 0;
        vld = 2'b11; wen = 2'b00; adr[0] = 16'h0010; adr[1] = 16'h0020; ben = '1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("s36_gnt", 64'(rdy_d1), (i % 2 == 0) ? 64'b01 : 64'b10);
            tick();
            cnt0 += int'(rv_d1[0]);
            cnt1 += int'(rv_d1[1]);
            if (i == 3) vld = '0;
        end
        tick();
        check_eq("s36_cnt0", 64'(cnt0), 64'(2));
        check_eq("s36_cnt1", 64'(cnt1), 64'(2));

        // Reset between a DLY=3 transfer and its response cycle.
        req(1, 1'b0, 'h10, 4'hF, 32'h0);
        tick();
        req(0, 1'b0, 'h10, 4'hF, 32'h0);
        tick();
        vld = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vld = 2'b11;
        #1;
        check_eq("s38_no_rsp", 64'(rv_d3), 64'(0));
        check_eq("s38_port0_wins", 64'(rdy_d3), 64'b01);
        tick();
        vld = '0;

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            for (int p = 0; p < SPN; p++) begin
                int sel;
                vld[p] = ($urandom_range(0, 3) != 0);
                wen[p] = 1'($urandom_range(0, 1));
                sel = $urandom_range(0, 9);
                if (sel == 0)     adr[p] = AW'($urandom_range(SIZ, 65535));
                else if (sel < 5) adr[p] = AW'($urandom_range(0, 15));
                else              adr[p] = AW'($urandom_range(0, SIZ - 1));
                ben[p] = 4'($urandom_range(0, 15));
                wdt[p] = $urandom;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tcb_lib_mem_arb.md
TCB_LIB_MEM_ARB -- requirements
Module: tcb_lib_mem_arb

Interface
REQ-001 SHALL have parameter SPN, default 2, number of subordinate ports (1..8).
REQ-002 SHALL have parameter AW, default 16, byte address width.
REQ-003 SHALL have parameter DW, default 32, data width (8, 16, 32 or 64); BEW = DW/8.
REQ-004 SHALL have parameter SIZ, default 4096, memory size in bytes, a multiple of BEW and at most 2**AW.
REQ-005 SHALL have parameter DLY, default 1, read response latency in cycles (0..4).
REQ-006 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-008 SHALL have port tcb_vld, input, SPN, per-port request valid.
REQ-009 SHALL have port tcb_rdy, output, SPN, per-port ready (grant).
REQ-010 SHALL have port tcb_wen, input, SPN, per-port write enable (1 = write, 0 = read).
REQ-011 SHALL have port tcb_adr, input, SPN x AW, per-port byte address.
REQ-012 SHALL have port tcb_ben, input, SPN x BEW, per-port byte enables.
REQ-013 SHALL have port tcb_wdt, input, SPN x DW, per-port write data.
REQ-014 SHALL have port tcb_rsp_vld, output, SPN, per-port response valid.
REQ-015 SHALL have port tcb_rdt, output, SPN x DW, per-port read data.
REQ-016 SHALL have port tcb_err, output, SPN, per-port error response.

Function
REQ-017 SHALL define a transfer on port p in a cycle as tcb_vld[p] & tcb_rdy[p].
REQ-018 SHALL drive at most one tcb_rdy bit high per cycle; tcb_rdy[p] is combinational from tcb_vld and the round-robin pointer ptr.
REQ-019 SHALL grant the first port with vld set, searching ptr, ptr+1, ... modulo SPN; no vld set gives no grant.
REQ-020 SHALL update ptr to (g+1) mod SPN after a transfer on port g, and hold ptr otherwise.
REQ-021 SHALL use word address adr[AW-1:log2(BEW)]; the low address bits are ignored, and ben lane b maps to byte word*BEW+b.
REQ-022 SHALL treat adr >= SIZ as out-of-range: no write, response err=1, rdt=0.
REQ-023 SHALL, on an in-range write transfer, write each byte lane whose ben bit is set at the end of that cycle; read response rdt=0, err=0.
REQ-024 SHALL, on an in-range read, return bytes with ben set from memory and 0 in lanes with ben clear.
REQ-025 SHALL present the response on the transfer port exactly DLY cycles after the transfer cycle with tcb_rsp_vld=1 for one cycle; DLY=0 means the same cycle, combinationally.
REQ-026 SHALL hold tcb_rdt=0 and tcb_err=0 whenever tcb_rsp_vld=0.
REQ-027 SHALL, for a read transferred in the cycle after a write to the same word, return the newly written data.
REQ-028 SHALL implement the DLY>0 response path as a per-port shift pipeline of {vld, err, rdt}, DLY stages deep, accepting one entry per cycle with no backpressure.
REQ-029 SHALL accept back-to-back transfers on the same port every cycle when no other port requests.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, set ptr=0, clear every pipeline stage, and drive tcb_rdy=0, tcb_rsp_vld=0, tcb_rdt=0, tcb_err=0.
REQ-031 SHALL NOT modify memory contents on reset, and memory contents SHALL NOT be initialised by reset.
REQ-032 SHALL discard in-flight responses when reset is asserted mid-operation; no tcb_rsp_vld pulse for them after reset release.
REQ-033 SHALL ignore requests while rst_n=0, and SHALL resume arbitration from port 0 in the first cycle after release.

Verification
REQ-034 SHALL cover this scenario (SPN=2, DLY=1): port0 writes adr=0x10, ben=1111, wdt=0xA5A5_1234, then reads adr=0x10 -> read response one cycle later has rdt=0xA5A5_1234, err=0.
REQ-035 SHALL cover this scenario: write 0xFFFF_FFFF to 0x20, then ben=0010 write wdt=0x0000_5600, then ben=1111 read -> rdt=0xFFFF_56FF; a ben=0001 read -> rdt=0x0000_00FF.
REQ-036 SHALL cover this scenario: both ports hold vld for 4 cycles from reset -> grants alternate 0,1,0,1 and each port gets exactly 2 responses.
REQ-037 SHALL cover this scenario: read adr=0x1000 (SIZ=4096) -> err=1, rdt=0; a write to 0x1000 leaves memory unchanged.
REQ-038 SHALL cover this scenario: DLY=3 read issued, rst_n=0 for one cycle before the response cycle -> no tcb_rsp_vld pulse; after release, ptr=0 and port0 wins when both ports request.
REQ-039 SHALL cover this scenario: DLY=0 read of previously written 0x0BAD_F00D -> rdt valid in the transfer cycle with rsp_vld=1.
